// File: rtl/range_session_ctrl.sv
// Session controller for the shared min/max range tracker.
// Two requesters compete for one tracker, which is granted round-robin.
// Each session clears the tracker, accumulates max/min/count over the owner's
// samples, and ends on owner finish or on an idle timeout. The block then
// reports range = max - min together with a one-cycle done pulse.
module range_session_ctrl #(
    parameter int DATA_W  = 10,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_go,
    input  logic [1:0]        req_finish,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] range_out,
    output logic [CNT_W-1:0]  sample_count,
    output logic              done,
    output logic              done_id,
    output logic              error
);

    // The timer never exceeds TIMEOUT-1, because reaching it forces the session out of BUSY.
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             owner_reg;
    logic             rr_reg;      // requester preferred when both ask at once
    logic [TMR_W-1:0] timer_reg;

    logic pick;
    logic owner_finish;
    logic owner_go;
    logic timeout_hit;

    // Arbitration, end-of-session detection and next-state selection.
    always_comb begin
        state_next   = state_reg;
        pick         = (req_go == 2'b11) ? rr_reg : ~req_go[0];
        owner_finish = req_finish[owner_reg];
        owner_go     = req_go[owner_reg];
        timeout_hit  = !sample_valid && !owner_finish && (timer_reg == TMR_LAST);
        case (state_reg)
            ST_IDLE: if (|req_go) state_next = ST_ARM;
            ST_ARM:  state_next = ST_BUSY;
            ST_BUSY: if (owner_finish || timeout_hit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs are plain decodes of the state and owner registers.
    always_comb begin
        busy = (state_reg != ST_IDLE);
        done = (state_reg == ST_DONE);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = busy && (owner_reg == 1'(gi));
        end
    endgenerate

    // State register, owner selection, round-robin pointer and done_id capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            owner_reg <= 1'b0;
            rr_reg    <= 1'b0;
            done_id   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && |req_go) begin
                owner_reg <= pick;
                rr_reg    <= ~pick;
            end
            if (state_reg == ST_BUSY && state_next == ST_DONE) begin
                done_id <= owner_reg;
            end
        end
    end

    // Tracker datapath: clear on ARM, accumulate in BUSY, publish the range in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            max_out      <= '0;
            min_out      <= '1;
            range_out    <= '0;
            sample_count <= '0;
            timer_reg    <= '0;
            error        <= 1'b0;
        end else begin
            case (state_reg)
                ST_ARM: begin
                    max_out      <= '0;
                    min_out      <= '1;
                    sample_count <= '0;
                    timer_reg    <= '0;
                    error        <= 1'b0;
                end
                ST_BUSY: begin
                    if (sample_valid) begin
                        if (sample_data > max_out) max_out <= sample_data;
                        if (sample_data < min_out) min_out <= sample_data;
                        if (sample_count != '1) sample_count <= sample_count + CNT_W'(1);
                        timer_reg <= '0;
                    end else if (timer_reg != TMR_LAST) begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                    // Finish still wins when combined with a go, but is flagged.
                    if (owner_finish && owner_go) error <= 1'b1;
                    if (timeout_hit) error <= 1'b1;
                end
                ST_DONE: begin
                    if (sample_count == '0) begin
                        range_out <= '0;
                        error     <= 1'b1;
                    end else begin
                        range_out <= max_out - min_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_range_session_ctrl.sv
// Randomized scoreboard bench for range_session_ctrl.
// The driver issues sessions and pushes the expected outcome (owner, max, min,
// count, range, error) computed from the sample list; a monitor pops and checks
// whenever the DUT grants (busy rises) or pulses done.
module tb_range_session_ctrl;

    localparam int DATA_W  = 10;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req_go = 2'b00;
    logic [1:0]        req_finish = 2'b00;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_data = '0;
    logic [1:0]        grant;
    logic              busy;
    logic [DATA_W-1:0] max_out;
    logic [DATA_W-1:0] min_out;
    logic [DATA_W-1:0] range_out;
    logic [CNT_W-1:0]  sample_count;
    logic              done;
    logic              done_id;
    logic              error;

    range_session_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .req_go(req_go), .req_finish(req_finish),
        .sample_valid(sample_valid), .sample_data(sample_data), .grant(grant),
        .busy(busy), .max_out(max_out), .min_out(min_out), .range_out(range_out),
        .sample_count(sample_count), .done(done), .done_id(done_id), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] mx;
        logic [DATA_W-1:0] mn;
        logic [DATA_W-1:0] rng;
        logic [CNT_W-1:0]  cnt;
        logic              err;
    } exp_t;

    exp_t              exp_q[$];
    logic              exp_grant_q[$];
    logic [DATA_W-1:0] stim_q[$];
    int                tests = 0;
    int                fails = 0;
    logic              model_rr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic abort_run(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: checks the owner at every grant and the results at every done pulse.
    initial begin : monitor
        logic prev_busy;
        logic eg;
        exp_t r;
        prev_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    if (exp_grant_q.size() == 0) begin
                        chk("unexpected_grant", 32'(grant), 32'd0);
                    end else begin
                        eg = exp_grant_q.pop_front();
                        chk("grant_arm", 32'(grant), eg ? 32'd2 : 32'd1);
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                        prev_busy = busy;
                    end else begin
                        r = exp_q.pop_front();
                        chk("done_id", 32'(done_id), 32'(r.id));
                        chk("grant_done", 32'(grant), r.id ? 32'd2 : 32'd1);
                        chk("max_out", 32'(max_out), 32'(r.mx));
                        chk("min_out", 32'(min_out), 32'(r.mn));
                        chk("sample_count", 32'(sample_count), 32'(r.cnt));
                        @(negedge clock);
                        chk("done_one_cycle", 32'(done), 32'd0);
                        chk("range_out", 32'(range_out), 32'(r.rng));
                        chk("error", 32'(error), 32'(r.err));
                        $display("[TB] session id=%0d n=%0d max=%0d min=%0d range=%0d err=%0d",
                                 r.id, r.cnt, r.mx, r.mn, r.rng, r.err);
                        prev_busy = busy;
                    end
                end else begin
                    prev_busy = busy;
                end
            end
        end
    end

    // Raise a request from IDLE, predict the owner, and wait until it is granted.
    task automatic request(input logic [1:0] go, output logic owner);
        int k;
        owner = (go == 2'b11) ? model_rr : (go[0] ? 1'b0 : 1'b1);
        model_rr = ~owner;
        exp_grant_q.push_back(owner);
        req_go = go;
        for (k = 0; k < 20; k++) begin
            @(negedge clock);
            if (grant != 2'b00) break;
        end
        if (k == 20) abort_run("grant_wait");
    endtask

    // mode 0: finish, 1: finish carrying the last sample, 2: finish with go, 3: timeout.
    task automatic run_session(input logic [1:0] go, input bit hold, input bit keep,
                               input int mode, input bit rnd_gap);
        logic       owner;
        logic [1:0] own_m;
        logic [1:0] oth_m;
        exp_t       r;
        int         n;
        int         cyc;
        int         k;
        n = stim_q.size();
        request(go, owner);
        own_m = owner ? 2'b10 : 2'b01;
        oth_m = ~own_m;
        if (!hold) req_go = 2'b00;
        r.id  = owner;
        r.cnt = (n > 255) ? 8'hFF : 8'(n);
        r.mx  = '0;
        r.mn  = '1;
        foreach (stim_q[j]) begin
            if (stim_q[j] > r.mx) r.mx = stim_q[j];
            if (stim_q[j] < r.mn) r.mn = stim_q[j];
        end
        r.rng = (n > 0) ? r.mx - r.mn : '0;
        r.err = (n == 0) || (mode == 3) || (mode == 2) || (hold && go[owner]);
        if (n == 0) begin
            r.mx = '0;
            r.mn = '1;
        end
        exp_q.push_back(r);
        tick();
        for (int s = 0; s < n; s++) begin
            if (mode == 1 && s == n - 1) break;
            if (rnd_gap) begin
                repeat ($urandom_range(0, TIMEOUT - 1)) begin
                    sample_valid = 1'b0;
                    req_finish = ($urandom_range(0, 1) == 1) ? oth_m : 2'b00;
                    tick();
                end
            end
            sample_valid = 1'b1;
            sample_data = stim_q[s];
            req_finish = 2'b00;
            tick();
        end
        sample_valid = 1'b0;
        req_finish = 2'b00;
        case (mode)
            0: begin
                req_finish = own_m;
                tick();
            end
            1: begin
                sample_valid = 1'b1;
                sample_data = stim_q[n - 1];
                req_finish = own_m;
                tick();
            end
            2: begin
                req_finish = own_m;
                req_go = req_go | own_m;
                tick();
                req_go = hold ? go : 2'b00;
            end
            default: begin
                cyc = 0;
                for (int c = 1; c <= TIMEOUT + 4; c++) begin
                    @(negedge clock);
                    if (done) begin
                        cyc = c;
                        break;
                    end
                    tick();
                end
                chk("timeout_latency", 32'(cyc), 32'(TIMEOUT + 1));
            end
        endcase
        sample_valid = 1'b0;
        req_finish = 2'b00;
        stim_q.delete();
        for (k = 0; k < 10; k++) begin
            @(negedge clock);
            if (!busy) break;
        end
        if (k == 10) abort_run("idle_wait");
        if (!keep) req_go = 2'b00;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) stim_q.push_back(DATA_W'($urandom_range(0, 1023)));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_max"}, 32'(max_out), 32'd0);
        chk({tag, "_min"}, 32'(min_out), 32'd1023);
        chk({tag, "_range"}, 32'(range_out), 32'd0);
        chk({tag, "_count"}, 32'(sample_count), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_done_id"}, 32'(done_id), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin : driver
        logic       own;
        logic [1:0] go;
        int         mode;
        int         n;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        tick();
        reset = 1'b0;
        tick();

        // Both requesters held: grants alternate 0, 1, 0.
        fill_random(2);
        run_session(2'b11, 1'b1, 1'b1, 0, 1'b0);
        fill_random(3);
        run_session(2'b11, 1'b1, 1'b1, 0, 1'b1);
        fill_random(1);
        run_session(2'b11, 1'b1, 1'b0, 0, 1'b0);

        // Basic session with known values: range 505.
        stim_q = '{10'd100, 10'd7, 10'd512};
        run_session(2'b01, 1'b0, 1'b0, 0, 1'b0);

        // Empty session, then pure timeout.
        run_session(2'b10, 1'b0, 1'b0, 0, 1'b0);
        run_session(2'b01, 1'b0, 1'b0, 3, 1'b0);

        // Last sample on the finish cycle, with non-owner finish noise: range 890.
        stim_q = '{10'd10, 10'd20, 10'd900};
        run_session(2'b10, 1'b0, 1'b0, 1, 1'b1);

        // Finish combined with owner go, then count saturation.
        fill_random(2);
        run_session(2'b01, 1'b0, 1'b0, 2, 1'b0);
        fill_random(260);
        run_session(2'b10, 1'b0, 1'b0, 0, 1'b0);

        // Randomized sessions.
        for (int i = 0; i < 25; i++) begin
            go = 2'($urandom_range(1, 3));
            n = $urandom_range(0, 6);
            mode = $urandom_range(0, 3);
            if (mode == 1 && n == 0) mode = 0;
            fill_random(n);
            run_session(go, 1'b0, 1'b0, mode, 1'b1);
        end

        // Reset in the middle of a session.
        request(2'b01, own);
        req_go = 2'b00;
        tick();
        sample_valid = 1'b1;
        sample_data = 10'd300;
        tick();
        sample_data = 10'd50;
        tick();
        sample_valid = 1'b0;
        reset = 1'b1;
        model_rr = 1'b0;
        @(negedge clock);
        check_reset_values("midreset");
        tick();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("no_done_after_reset", 32'(done), 32'd0);
        end
        fill_random(3);
        run_session(2'b11, 1'b0, 1'b0, 0, 1'b1);

        repeat (4) @(negedge clock);
        chk("pending_results", 32'(exp_q.size()), 32'd0);
        chk("pending_grants", 32'(exp_grant_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin : watchdog
        #500000;
        abort_run("global_timeout");
    end

endmodule
